fm_cmn_bram_02: RTL and testbench

Parametrised dual-port block RAM: the next generation of the common dual-port BRAM. It adds byte-lane write enables, per-port read enables, a selectable port-A read-during-write mode, an optional output register stage, per-port valid strobes and a same-address collision flag. It is instantiated by cache, FIFO and texture-buffer blocks that need byte-granular updates and a pipelined, valid-qualified read path.

---
 rtl/fm_cmn_bram_pkg.sv | 17 +
 rtl/fm_cmn_bram_opipe.sv | 55 +++++
 rtl/fm_cmn_bram_02.sv | 53 +++++
 tb/tb_fm_cmn_bram_02.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fm_cmn_bram_pkg.sv
// fm_cmn_bram_pkg: shared mode constants and byte-lane merge for the dual-port BRAM family.
package fm_cmn_bram_pkg;
  localparam int P_MODE_WRITE_FIRST = 0;
  localparam int P_MODE_READ_FIRST  = 1;
  localparam int P_MODE_NO_CHANGE   = 2;
  // Widest supported word; narrower callers cast in and out.
  localparam int P_MERGE_W  = 256;
  localparam int P_MERGE_BE = P_MERGE_W / 8;
  function automatic logic [P_MERGE_W-1:0] byte_merge(
    input logic [P_MERGE_W-1:0]  old_w,
    input logic [P_MERGE_W-1:0]  new_w,
    input logic [P_MERGE_BE-1:0] be
  );
    for (int i = 0; i < P_MERGE_BE; i++)
      byte_merge[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
  endfunction
endpackage

// File: rtl/fm_cmn_bram_opipe.sv
// fm_cmn_bram_opipe: per-port read output stage with hold-on-disable and optional extra register.
module fm_cmn_bram_opipe
  import fm_cmn_bram_pkg::*;
#(
  parameter int P_WIDTH = 32,
  parameter int P_OREG  = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld,
  input  logic               vld,
  input  logic               flg,
  input  logic [P_WIDTH-1:0] d,
  output logic [P_WIDTH-1:0] q,
  output logic               valid,
  output logic               flag
);
  logic [P_WIDTH-1:0] d1;
  logic               v1, f1;
  always_ff @(posedge clk) begin
    if (rst) begin
      d1 <= '0;
      v1 <= 1'b0;
      f1 <= 1'b0;
    end else begin
      if (ld) d1 <= d;
      v1 <= vld;
      f1 <= flg;
    end
  end
  generate
    if (P_OREG != 0) begin : g_oreg
      logic [P_WIDTH-1:0] d2;
      logic               v2, f2;
      always_ff @(posedge clk) begin
        if (rst) begin
          d2 <= '0;
          v2 <= 1'b0;
          f2 <= 1'b0;
        end else begin
          d2 <= d1;
          v2 <= v1;
          f2 <= f1;
        end
      end
      assign q     = d2;
      assign valid = v2;
      assign flag  = f2;
    end else begin : g_direct
      assign q     = d1;
      assign valid = v1;
      assign flag  = f1;
    end
  endgenerate
endmodule

// File: rtl/fm_cmn_bram_02.sv
// fm_cmn_bram_02: dual-port BRAM with byte-lane writes, selectable port-A RDW mode and valid-qualified reads.
module fm_cmn_bram_02
  import fm_cmn_bram_pkg::*;
#(
  parameter int P_WIDTH  = 32,
  parameter int P_RANGE  = 9,
  parameter int P_DEPTH  = 1 << P_RANGE,
  parameter int P_BE     = P_WIDTH / 8,
  parameter int P_MODE_A = 0,
  parameter int P_OREG   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic [P_BE-1:0]    wea,
  input  logic [P_RANGE-1:0] a,
  input  logic [P_WIDTH-1:0] di,
  output logic [P_WIDTH-1:0] spo,
  output logic               spo_valid,
  input  logic               enb,
  input  logic [P_RANGE-1:0] dpra,
  output logic [P_WIDTH-1:0] dpo,
  output logic               dpo_valid,
  output logic               coll
);
  logic [P_WIDTH-1:0] mem [P_DEPTH];
  logic               acc_a, acc_b, wr, ld_a, coll_in, spo_coll;
  logic [P_WIDTH-1:0] old_a, old_b, merged, rd_a;
  assign acc_a   = ena & ~rst;
  assign acc_b   = enb & ~rst;
  assign wr      = acc_a & |wea;
  assign old_a   = mem[a];
  assign old_b   = mem[dpra];
  assign merged  = P_WIDTH'(byte_merge(P_MERGE_W'(old_a), P_MERGE_W'(di), P_MERGE_BE'(wea)));
  assign rd_a    = (P_MODE_A == P_MODE_WRITE_FIRST) ? merged : old_a;
  // No-change mode freezes the data register on any write but still strobes valid.
  assign ld_a    = acc_a & ~((P_MODE_A == P_MODE_NO_CHANGE) & (|wea));
  assign coll_in = acc_b & wr & (dpra == a);
  always_ff @(posedge clk) begin
    for (int i = 0; i < P_BE; i++)
      if (acc_a && wea[i]) mem[a][8*i +: 8] <= di[8*i +: 8];
  end
  fm_cmn_bram_opipe #(.P_WIDTH(P_WIDTH), .P_OREG(P_OREG)) u_pipe_a (
    .clk(clk), .rst(rst), .ld(ld_a), .vld(acc_a), .flg(1'b0), .d(rd_a),
    .q(spo), .valid(spo_valid), .flag(spo_coll)
  );
  fm_cmn_bram_opipe #(.P_WIDTH(P_WIDTH), .P_OREG(P_OREG)) u_pipe_b (
    .clk(clk), .rst(rst), .ld(acc_b), .vld(acc_b), .flg(coll_in), .d(old_b),
    .q(dpo), .valid(dpo_valid), .flag(coll)
  );
  logic unused_ok;
  assign unused_ok = spo_coll;
endmodule

// File: tb/tb_fm_cmn_bram_02.sv
// tb_fm_cmn_bram_02: four DUT flavours (write-first, read-first, no-change, write-first+oreg) on shared stimulus.
module tb_fm_cmn_bram_02;
  logic        clk = 1'b0;
  logic        rst, ena, enb;
  logic [3:0]  wea;
  logic [8:0]  a, dpra;
  logic [31:0] di;
  logic [31:0] spo [4];
  logic [31:0] dpo [4];
  logic        spo_valid [4];
  logic        dpo_valid [4];
  logic        coll [4];
  logic [31:0] ref_mem [512];
  logic [31:0] m_spo [4];
  logic [31:0] m_dpo [4];
  logic        m_sv [4];
  logic        m_dv [4];
  logic        m_coll [4];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_dut
      fm_cmn_bram_02 #(.P_MODE_A(g == 3 ? 0 : g), .P_OREG(g == 3 ? 1 : 0)) u_dut (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .a(a), .di(di),
        .spo(spo[g]), .spo_valid(spo_valid[g]),
        .enb(enb), .dpra(dpra), .dpo(dpo[g]), .dpo_valid(dpo_valid[g]), .coll(coll[g])
      );
    end
  endgenerate

  // Drive one cycle, then advance the reference: instances 0..2 are 1-cycle RAMs in
  // each read-during-write mode, instance 3 is instance 0 seen one cycle later.
  task automatic step(input logic r, input logic e, input logic [3:0] w, input logic [8:0] aa,
                      input logic [31:0] d, input logic eb, input logic [8:0] ba);
    logic [31:0] mask, old, nw;
    rst = r; ena = e; wea = w; a = aa; di = d; enb = eb; dpra = ba;
    @(posedge clk);
    mask = '0;
    for (int i = 0; i < 4; i++) if (w[i]) mask[8*i +: 8] = 8'hFF;
    old = ref_mem[aa];
    nw  = (old & ~mask) | (d & mask);
    m_spo[3] = r ? 32'h0 : m_spo[0];
    m_sv[3]  = r ? 1'b0 : m_sv[0];
    m_dpo[3] = r ? 32'h0 : m_dpo[0];
    m_dv[3]  = r ? 1'b0 : m_dv[0];
    m_coll[3] = r ? 1'b0 : m_coll[0];
    for (int m = 0; m < 3; m++) begin
      if (r) begin
        m_spo[m] = 0; m_sv[m] = 0; m_dpo[m] = 0; m_dv[m] = 0; m_coll[m] = 0;
      end else begin
        m_sv[m] = e;
        if (e) begin
          if (m == 0) m_spo[m] = nw;
          else if (m == 1 || w == 4'h0) m_spo[m] = old;
        end
        m_dv[m]   = eb;
        m_coll[m] = eb && e && (w != 4'h0) && (ba == aa);
        if (eb) m_dpo[m] = ref_mem[ba];
      end
    end
    if (!r && e) ref_mem[aa] = nw;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'h0, 9'd0, 32'h0, 1'b0, 9'd0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 4'h0, 9'd0, 32'h0, 1'b0, 9'd0);
    step(1'b1, 1'b0, 4'h0, 9'd0, 32'h0, 1'b0, 9'd0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({spo[i], spo_valid[i], dpo[i], dpo_valid[i], coll[i]} !== '0) begin
        $display("FAIL reset inst%0d: spo=%h sv=%b dpo=%h dv=%b coll=%b, want all 0",
                 i, spo[i], spo_valid[i], dpo[i], dpo_valid[i], coll[i]);
        errors++;
      end
    end
    for (int i = 0; i < 512; i++) step(1'b0, 1'b1, 4'hF, 9'(i), $urandom, 1'b0, 9'd0);
    idle();
  endtask

  task automatic test_reset_hold();
    step(1'b0, 1'b1, 4'hF, 9'd3, 32'hDEADBEEF, 1'b0, 9'd0);
    step(1'b1, 1'b1, 4'hF, 9'd3, 32'h0, 1'b1, 9'd3);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({spo[i], spo_valid[i], dpo[i], dpo_valid[i], coll[i]} !== '0) begin
        $display("FAIL reset_mid inst%0d: spo=%h sv=%b dpo=%h dv=%b, want all 0",
                 i, spo[i], spo_valid[i], dpo[i], dpo_valid[i]);
        errors++;
      end
    end
    step(1'b0, 1'b1, 4'h0, 9'd3, 32'h0, 1'b1, 9'd3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (spo[i] !== 32'hDEADBEEF || spo_valid[i] !== 1'b1 || dpo[i] !== 32'hDEADBEEF || dpo_valid[i] !== 1'b1) begin
        $display("FAIL hold_read inst%0d: spo=%h sv=%b dpo=%h dv=%b, want deadbeef/1",
                 i, spo[i], spo_valid[i], dpo[i], dpo_valid[i]);
        errors++;
      end
    end
    checks++;
    if (spo_valid[3] !== 1'b0 || dpo_valid[3] !== 1'b0) begin
      $display("FAIL oreg_early: sv=%b dv=%b, want 0/0", spo_valid[3], dpo_valid[3]);
      errors++;
    end
    idle();
    checks++;
    if (spo[3] !== 32'hDEADBEEF || spo_valid[3] !== 1'b1 || dpo[3] !== 32'hDEADBEEF || dpo_valid[3] !== 1'b1) begin
      $display("FAIL oreg_read: spo=%h sv=%b dpo=%h dv=%b, want deadbeef/1",
               spo[3], spo_valid[3], dpo[3], dpo_valid[3]);
      errors++;
    end
    checks++;
    if (dpo[0] !== 32'hDEADBEEF || dpo_valid[0] !== 1'b0 || spo_valid[0] !== 1'b0) begin
      $display("FAIL disabled_hold: dpo=%h dv=%b sv=%b, want deadbeef/0/0", dpo[0], dpo_valid[0], spo_valid[0]);
      errors++;
    end
  endtask

  task automatic test_byte_merge();
    step(1'b0, 1'b1, 4'hF, 9'd5, 32'h11223344, 1'b0, 9'd0);
    step(1'b0, 1'b1, 4'b0101, 9'd5, 32'hAABBCCDD, 1'b0, 9'd0);
    checks++;
    if (spo[0] !== 32'h11BB33DD || spo_valid[0] !== 1'b1) begin
      $display("FAIL write_first: spo=%h sv=%b, want 11bb33dd/1", spo[0], spo_valid[0]);
      errors++;
    end
    checks++;
    if (spo[1] !== 32'h11223344 || spo_valid[1] !== 1'b1) begin
      $display("FAIL read_first: spo=%h sv=%b, want 11223344/1", spo[1], spo_valid[1]);
      errors++;
    end
    checks++;
    if (spo[2] !== 32'hDEADBEEF || spo_valid[2] !== 1'b1) begin
      $display("FAIL no_change: spo=%h sv=%b, want deadbeef/1", spo[2], spo_valid[2]);
      errors++;
    end
    step(1'b0, 1'b0, 4'h0, 9'd0, 32'h0, 1'b1, 9'd5);
    checks++;
    if (dpo[0] !== 32'h11BB33DD || dpo_valid[0] !== 1'b1) begin
      $display("FAIL merge_readback: dpo=%h dv=%b, want 11bb33dd/1", dpo[0], dpo_valid[0]);
      errors++;
    end
  endtask

  task automatic test_collision();
    step(1'b0, 1'b1, 4'hF, 9'd7, 32'h0, 1'b0, 9'd0);
    step(1'b0, 1'b1, 4'hF, 9'd7, 32'h5A5A5A5A, 1'b1, 9'd7);
    checks++;
    if (dpo[0] !== 32'h0 || coll[0] !== 1'b1 || dpo_valid[0] !== 1'b1) begin
      $display("FAIL collision: dpo=%h coll=%b dv=%b, want 0/1/1", dpo[0], coll[0], dpo_valid[0]);
      errors++;
    end
    step(1'b0, 1'b0, 4'h0, 9'd0, 32'h0, 1'b1, 9'd7);
    checks++;
    if (dpo[0] !== 32'h5A5A5A5A || coll[0] !== 1'b0 || coll[3] !== 1'b1 || dpo[3] !== 32'h0) begin
      $display("FAIL coll_repeat: dpo0=%h coll0=%b coll3=%b dpo3=%h, want 5a5a5a5a/0/1/0",
               dpo[0], coll[0], coll[3], dpo[3]);
      errors++;
    end
    idle();
    checks++;
    if (dpo[3] !== 32'h5A5A5A5A || coll[3] !== 1'b0) begin
      $display("FAIL coll_oreg: dpo3=%h coll3=%b, want 5a5a5a5a/0", dpo[3], coll[3]);
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'hF, 9'(i), 32'hC0DE0000 + i, 1'b0, 9'd0);
    idle();
    for (int k = 0; k < 6; k++) begin
      if (k < 4) step(1'b0, 1'b0, 4'h0, 9'd0, 32'h0, 1'b1, 9'(k));
      else idle();
      checks++;
      if (k == 0 || k == 5) begin
        if (dpo_valid[3] !== 1'b0) begin
          $display("FAIL latency k=%0d: dv=%b, want 0", k, dpo_valid[3]);
          errors++;
        end
      end else if (dpo_valid[3] !== 1'b1 || dpo[3] !== 32'hC0DE0000 + 32'(k - 1)) begin
        $display("FAIL latency k=%0d: dpo=%h dv=%b, want %h/1", k, dpo[3], dpo_valid[3], 32'hC0DE0000 + 32'(k - 1));
        errors++;
      end
    end
  endtask

  task automatic test_reset_pipeline();
    step(1'b0, 1'b1, 4'h0, 9'd1, 32'h0, 1'b1, 9'd1);
    step(1'b1, 1'b0, 4'h0, 9'd0, 32'h0, 1'b1, 9'd2);
    checks++;
    if (dpo_valid[3] !== 1'b0 || spo_valid[3] !== 1'b0 || dpo[3] !== 32'h0) begin
      $display("FAIL rst_pipe: dv=%b sv=%b dpo=%h, want 0/0/0", dpo_valid[3], spo_valid[3], dpo[3]);
      errors++;
    end
    idle();
    checks++;
    if (dpo_valid[3] !== 1'b0 || spo_valid[3] !== 1'b0) begin
      $display("FAIL rst_pipe_drain: dv=%b sv=%b, want 0/0", dpo_valid[3], spo_valid[3]);
      errors++;
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 24) == 0, 1'($urandom), 4'($urandom), 9'($urandom_range(0, 7)),
           $urandom, 1'($urandom), 9'($urandom_range(0, 7)));
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (spo[i] !== m_spo[i] || spo_valid[i] !== m_sv[i] || dpo[i] !== m_dpo[i] ||
            dpo_valid[i] !== m_dv[i] || coll[i] !== m_coll[i]) begin
          $display("FAIL random n=%0d inst%0d: spo=%h/%b dpo=%h/%b coll=%b, want %h/%b %h/%b %b",
                   n, i, spo[i], spo_valid[i], dpo[i], dpo_valid[i], coll[i],
                   m_spo[i], m_sv[i], m_dpo[i], m_dv[i], m_coll[i]);
          errors++;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; enb = 1'b0; wea = '0; a = '0; dpra = '0; di = '0;
    #1;
    test_reset();
    test_reset_hold();
    test_byte_merge();
    test_collision();
    test_back_to_back();
    test_reset_pipeline();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
